gin_ctrl: RTL and testbench
===========================

GIN_CTRL -- requirements
Module: gin_ctrl

Interface
REQ-001 SHALL have parameter ID_BITWIDTH, default 4: width of the row tag and the column tag.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 8: width of the payload.
REQ-003 SHALL have parameter SLV_NUM, default 6: number of bus slaves being configured.
REQ-004 SHALL have parameter CNT_BITWIDTH, default 5: width of the row/column count inputs.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_start  in  1  one-cycle job start, sampled only in IDLE.
REQ-008 i_id_cfg  in  SLV_NUM*ID_BITWIDTH  slave IDs for the bus.
REQ-009 i_row_base  in  ID_BITWIDTH  first row tag.
REQ-010 i_col_base  in  ID_BITWIDTH  first column tag.
REQ-011 i_num_row  in  CNT_BITWIDTH  rows per job.
REQ-012 i_num_col  in  CNT_BITWIDTH  columns per row.
REQ-013 i_data, i_data_valid, o_data_ready  in/in/out  DATA_BITWIDTH/1/1  payload source handshake.
REQ-014 o_packet, o_valid, i_ready  out/out/in  2*ID_BITWIDTH+DATA_BITWIDTH/1/1  bus packet {row_tag, col_tag, data}, MSB first.
REQ-015 o_id, o_id_valid  out/out  SLV_NUM*ID_BITWIDTH/1  bus ID configuration port.
REQ-016 o_busy, o_done  out/out  1/1  busy = state is not IDLE; done = one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, CFG, STREAM, DRAIN and DONE.
REQ-018 IDLE with i_start=1: SHALL latch i_id_cfg, bases and counts, then go to CFG.
REQ-019 i_start outside IDLE SHALL be ignored.
REQ-020 CFG SHALL last exactly one cycle, driving o_id_valid=1 with o_id = latched IDs.
REQ-021 Leaving CFG: SHALL go to STREAM if both counts are nonzero, else to DONE.
REQ-022 Outside CFG, o_id SHALL be 0 and o_id_valid SHALL be 0.
REQ-023 In STREAM: o_data_ready = !o_valid | i_ready.
REQ-024 An accepted word (i_data_valid & o_data_ready) SHALL load the output register on the next edge and set o_valid=1, giving 1-cycle latency.
REQ-025 The row tag SHALL be (i_row_base + row_cnt) mod 2^ID_BITWIDTH.
REQ-026 The column tag SHALL be (i_col_base + col_cnt) mod 2^ID_BITWIDTH.
REQ-027 o_valid SHALL stay high with o_packet stable until i_ready=1; accept-and-drain in the same cycle SHALL sustain 1 packet/cycle.
REQ-028 On each accept, col_cnt SHALL increment; at num_col-1 it SHALL wrap to 0 and row_cnt SHALL increment.
REQ-029 On accepting the word with row_cnt=num_row-1 and col_cnt=num_col-1: SHALL go to DRAIN, with o_data_ready=0 from the next cycle.
REQ-030 DRAIN SHALL go to DONE in the cycle the last packet handshakes; if it handshakes on the DRAIN entry edge, the FSM SHALL still pass through DRAIN for one cycle.
REQ-031 DONE SHALL last one cycle with o_done=1, then go to IDLE.
REQ-032 o_data_ready SHALL be 0 in every state except STREAM.

Reset
REQ-033 When i_rst_n=0, immediately: state = IDLE; counters, latched config and output register = 0.
REQ-034 When i_rst_n=0, all outputs SHALL be 0.
REQ-035 Reset mid-job SHALL drop o_valid without a handshake.
REQ-036 Reset deassertion SHALL take effect on the next i_clk edge.

Configuration
REQ-037 With GIN_CTRL_PERF_EN defined: SHALL add output o_stall_cnt[15:0], counting cycles with o_valid & !i_ready.
REQ-038 o_stall_cnt SHALL clear on a job start, saturate at 0xFFFF and be 0 on reset.
REQ-039 Without GIN_CTRL_PERF_EN: the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-040 Reset mid-STREAM -> all outputs 0 asynchronously; restart succeeds.
REQ-041 Start with IDs {5,4,3,2,1,0} -> one-cycle o_id_valid pulse with o_id=0x543210 in the cycle after start.
REQ-042 Job row_base=2, col_base=5, 2x3, data 0x11..0x16, i_ready=1 -> packets 0x2511, 0x2612, 0x2713, 0x3514, 0x3615, 0x3716 on consecutive cycles; o_done 2 cycles after last accept.
REQ-043 col_base=15, num_col=2 -> column tags 15, 0 (mod wrap); row tag increments once per 2 packets.
REQ-044 i_ready low for 3 cycles mid-job -> o_packet held stable, o_data_ready=0, no loss or duplication; with GIN_CTRL_PERF_EN o_stall_cnt=3.
REQ-045 num_row=0 -> CFG pulse, then o_done, no packets; i_start while busy -> ignored.

Source files
------------

// File: rtl/gin_ctrl.sv
// rtl/gin_ctrl.sv - grid packet injector controller: bus ID config then tagged payload streaming (optional GIN_CTRL_PERF_EN stall counter)
module gin_ctrl #(
    parameter int ID_BITWIDTH   = 4,
    parameter int DATA_BITWIDTH = 8,
    parameter int SLV_NUM       = 6,
    parameter int CNT_BITWIDTH  = 5
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_start,
    input  logic [SLV_NUM*ID_BITWIDTH-1:0]         i_id_cfg,
    input  logic [ID_BITWIDTH-1:0]                 i_row_base,
    input  logic [ID_BITWIDTH-1:0]                 i_col_base,
    input  logic [CNT_BITWIDTH-1:0]                i_num_row,
    input  logic [CNT_BITWIDTH-1:0]                i_num_col,
    input  logic [DATA_BITWIDTH-1:0]               i_data,
    input  logic                                   i_data_valid,
    output logic                                   o_data_ready,
    output logic [2*ID_BITWIDTH+DATA_BITWIDTH-1:0] o_packet,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [SLV_NUM*ID_BITWIDTH-1:0]         o_id,
    output logic                                   o_id_valid,
    output logic                                   o_busy,
    output logic                                   o_done
`ifdef GIN_CTRL_PERF_EN
    ,
    output logic [15:0]                            o_stall_cnt
`endif
);

    localparam int SUM_W = (ID_BITWIDTH > CNT_BITWIDTH) ? ID_BITWIDTH : CNT_BITWIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CFG    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                          state;
    logic [SLV_NUM*ID_BITWIDTH-1:0]  id_cfg_q;
    logic [ID_BITWIDTH-1:0]          row_base_q;
    logic [ID_BITWIDTH-1:0]          col_base_q;
    logic [CNT_BITWIDTH-1:0]         num_row_q;
    logic [CNT_BITWIDTH-1:0]         num_col_q;
    logic [CNT_BITWIDTH-1:0]         row_cnt;
    logic [CNT_BITWIDTH-1:0]         col_cnt;
    logic [SUM_W-1:0]                row_sum;
    logic [SUM_W-1:0]                col_sum;
    logic [ID_BITWIDTH-1:0]          row_tag;
    logic [ID_BITWIDTH-1:0]          col_tag;
    logic                            accept;
    logic                            row_last;
    logic                            col_last;

    // Tags are base + offset truncated to the tag width, so they wrap modulo 2^ID_BITWIDTH
    assign row_sum  = SUM_W'(row_base_q) + SUM_W'(row_cnt);
    assign col_sum  = SUM_W'(col_base_q) + SUM_W'(col_cnt);
    assign row_tag  = row_sum[ID_BITWIDTH-1:0];
    assign col_tag  = col_sum[ID_BITWIDTH-1:0];

    assign row_last = (row_cnt == num_row_q - CNT_BITWIDTH'(1));
    assign col_last = (col_cnt == num_col_q - CNT_BITWIDTH'(1));

    // Output register may be refilled in the same cycle it drains, sustaining one packet per cycle
    assign o_data_ready = (state == STREAM) && (!o_valid || i_ready);
    assign accept       = i_data_valid && o_data_ready;
    assign o_busy       = (state != IDLE);

    // Job sequencer: config pulse, payload streaming with tag counters, drain of last packet, done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            id_cfg_q   <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            num_row_q  <= '0;
            num_col_q  <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            o_packet   <= '0;
            o_valid    <= 1'b0;
            o_id       <= '0;
            o_id_valid <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        id_cfg_q   <= i_id_cfg;
                        row_base_q <= i_row_base;
                        col_base_q <= i_col_base;
                        num_row_q  <= i_num_row;
                        num_col_q  <= i_num_col;
                        row_cnt    <= '0;
                        col_cnt    <= '0;
                        o_id       <= i_id_cfg;
                        o_id_valid <= 1'b1;
                        state      <= CFG;
                    end
                end
                CFG: begin
                    o_id       <= '0;
                    o_id_valid <= 1'b0;
                    if ((num_row_q != '0) && (num_col_q != '0)) begin
                        state <= STREAM;
                    end else begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end
                STREAM: begin
                    if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                    end
                    if (accept) begin
                        o_packet <= {row_tag, col_tag, i_data};
                        o_valid  <= 1'b1;
                        if (col_last) begin
                            col_cnt <= '0;
                            if (row_last) begin
                                state <= DRAIN;
                            end else begin
                                row_cnt <= row_cnt + CNT_BITWIDTH'(1);
                            end
                        end else begin
                            col_cnt <= col_cnt + CNT_BITWIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The last packet was loaded on entry, so DRAIN always spans at least one cycle
                    if (!o_valid || i_ready) begin
                        o_valid <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GIN_CTRL_PERF_EN
    // Back-pressure counter: cycles a packet waits on the bus, cleared per job, saturating
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if ((state == IDLE) && i_start) begin
            o_stall_cnt <= '0;
        end else if (o_valid && !i_ready && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gin_ctrl.sv
// tb/tb_gin_ctrl.sv - directed self-checking bench for gin_ctrl
module tb_gin_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [23:0] i_id_cfg;
    logic [3:0]  i_row_base;
    logic [3:0]  i_col_base;
    logic [4:0]  i_num_row;
    logic [4:0]  i_num_col;
    logic [7:0]  i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [15:0] o_packet;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_id;
    logic        o_id_valid;
    logic        o_busy;
    logic        o_done;
`ifdef GIN_CTRL_PERF_EN
    logic [15:0] o_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    gin_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_id_cfg     (i_id_cfg),
        .i_row_base   (i_row_base),
        .i_col_base   (i_col_base),
        .i_num_row    (i_num_row),
        .i_num_col    (i_num_col),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_packet     (o_packet),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_id         (o_id),
        .o_id_valid   (o_id_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
`ifdef GIN_CTRL_PERF_EN
        ,
        .o_stall_cnt  (o_stall_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_packet"}, o_packet, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_dready"}, o_data_ready, 0);
        chk({tag, "_id"}, o_id, 0);
        chk({tag, "_idvalid"}, o_id_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
`ifdef GIN_CTRL_PERF_EN
        chk({tag, "_stall"}, o_stall_cnt, 0);
`endif
    endtask

    // Starts a job, checks the config pulse, then streams payload until o_done (bounded)
    task automatic run_job(input logic [23:0] ids, input logic [3:0] rb, input logic [3:0] cb,
                           input logic [4:0] nr, input logic [4:0] nc, input logic [7:0] d0,
                           input int stall_from, input int stall_len, input int busy_start_cyc,
                           output int acc_last, output int pkt_first, output int pkt_last,
                           output int n_out, output int done_c);
        int nwords;
        int sent;
        logic seen_done;
        nwords    = nr * nc;
        sent      = 0;
        acc_last  = -1;
        pkt_first = -1;
        pkt_last  = -1;
        n_out     = 0;
        done_c    = -1;
        seen_done = 1'b0;
        @(posedge i_clk); #1;
        i_id_cfg   = ids;
        i_row_base = rb;
        i_col_base = cb;
        i_num_row  = nr;
        i_num_col  = nc;
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start    = 1'b0;
        @(negedge i_clk);
        chk("cfg_idvalid", o_id_valid, 1);
        chk("cfg_id", o_id, ids);
        chk("cfg_busy", o_busy, 1);
        chk("cfg_dready", o_data_ready, 0);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge i_clk); #1;
            i_data_valid = (sent < nwords);
            i_data       = d0 + 8'(sent);
            i_ready      = !(cyc >= stall_from && cyc < stall_from + stall_len);
            i_start      = (cyc == busy_start_cyc);
            @(negedge i_clk);
            if (cyc == 0) chk("id_clear", {o_id_valid, o_id}, 0);
            if (i_data_valid && o_data_ready) begin
                acc_last = cyc;
                sent++;
            end
            if (o_valid && !i_ready && exp_q.size() > 0) begin
                chk("hold_pkt", o_packet, exp_q[0]);
                chk("hold_dready", o_data_ready, 0);
            end
            if (o_valid && i_ready) begin
                if (pkt_first < 0) pkt_first = cyc;
                pkt_last = cyc;
                n_out++;
                if (exp_q.size() > 0) chk("pkt", o_packet, exp_q.pop_front());
                else chk("extra_pkt", o_valid, 0);
            end
            if (o_done) begin
                done_c    = cyc;
                seen_done = 1'b1;
                break;
            end
        end
        chk("done_seen", seen_done, 1);
        chk("pkts_left", exp_q.size(), 0);
        @(posedge i_clk); #1;
        i_data_valid = 1'b0;
        i_ready      = 1'b0;
        i_start      = 1'b0;
        @(negedge i_clk);
        chk("done_pulse_end", o_done, 0);
        chk("idle_busy", o_busy, 0);
    endtask

    initial begin
        int acc_last, pkt_first, pkt_last, n_out, done_c;
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_id_cfg     = '0;
        i_row_base   = '0;
        i_col_base   = '0;
        i_num_row    = '0;
        i_num_col    = '0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_ready      = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk_outputs_zero("rst");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // 2x3 job at row 2 / col 5 with full-rate sink
        exp_q = '{16'h2511, 16'h2612, 16'h2713, 16'h3514, 16'h3615, 16'h3716};
        run_job(24'h543210, 4'd2, 4'd5, 5'd2, 5'd3, 8'h11, -1, 0, -1,
                acc_last, pkt_first, pkt_last, n_out, done_c);
        chk("j1_npkts", n_out, 6);
        chk("j1_span", pkt_last - pkt_first, 5);
        chk("j1_done_lat", done_c - acc_last, 2);

        // Reset while a packet is pending, outputs must fall without a clock edge
        @(posedge i_clk); #1;
        i_id_cfg  = 24'hABCDEF;
        i_num_row = 5'd2;
        i_num_col = 5'd2;
        i_start   = 1'b1;
        @(posedge i_clk); #1;
        i_start      = 1'b0;
        @(posedge i_clk); #1;
        i_data_valid = 1'b1;
        i_data       = 8'h55;
        i_ready      = 1'b0;
        @(posedge i_clk); #1;
        i_data_valid = 1'b0;
        chk("pre_rst_valid", o_valid, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Restart after reset; tags wrap on both row and column
        exp_q = '{16'hFF40, 16'hF041, 16'h0F42, 16'h0043};
        run_job(24'h000001, 4'd15, 4'd15, 5'd2, 5'd2, 8'h40, -1, 0, -1,
                acc_last, pkt_first, pkt_last, n_out, done_c);
        chk("j2_npkts", n_out, 4);

        // Three-cycle sink stall mid-job plus a start request while busy
        exp_q = '{16'h00A0, 16'h01A1, 16'h02A2, 16'h10A3, 16'h11A4, 16'h12A5};
        run_job(24'h123456, 4'd0, 4'd0, 5'd2, 5'd3, 8'hA0, 2, 3, 1,
                acc_last, pkt_first, pkt_last, n_out, done_c);
        chk("j3_npkts", n_out, 6);
`ifdef GIN_CTRL_PERF_EN
        chk("j3_stall_cnt", o_stall_cnt, 3);
`endif
        @(negedge i_clk);
        chk("j3_no_restart", o_busy, 0);

        // Zero rows: config pulse then done with no packets
        exp_q.delete();
        run_job(24'h0F0F0F, 4'd1, 4'd1, 5'd0, 5'd3, 8'h00, -1, 0, -1,
                acc_last, pkt_first, pkt_last, n_out, done_c);
        chk("j4_npkts", n_out, 0);
        chk("j4_done_cyc", done_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
